// File: rtl/btn_pulse_gen_if.sv
// Pushbutton conditioning bus between the board-facing stimulus and btn_pulse_gen.
//   btn_raw   : raw pushbutton levels, asynchronous and bouncy, 1 = pressed
//   btn_pulse : registered one-cycle pulse per accepted press
//   btn_level : registered debounced level, 1 = held
// master drives the raw buttons and observes the conditioned outputs;
// slave is the conditioner itself.
interface btn_pulse_gen_if #(
    parameter int NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [NUM_BTN-1:0] btn_level;

    modport master (
        output btn_raw,
        input  btn_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        output btn_pulse,
        output btn_level
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: turns raw pushbuttons (bit 0 = ent, bit 1 = clr, bit 2 = change)
// into clean single-cycle command pulses and debounced levels for the lock ASM.
// Each button has a 2-flop synchronizer, a debounce FSM with a stable-cycle
// counter, and a press-edge one-shot. With ONE_HOT=1 at most one pulse bit is
// high per cycle (lowest index wins, losers are dropped, not deferred).
// Ports:
//   clk  : system clock, shared with the ASM
//   rst  : asynchronous active-high reset
//   bus  : btn_pulse_gen_if.slave (btn_raw in, btn_pulse/btn_level out)
module btn_pulse_gen #(
    parameter int NUM_BTN   = 3,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20,
    parameter int ONE_HOT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    btn_pulse_gen_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    // Terminal count: DB_CYCLES-1 always fits in CNT_W bits for the legal range.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [NUM_BTN-1:0] req;        // press accepted on this edge (P_W -> HELD)
    logic [NUM_BTN-1:0] level_d;    // debounced level after this edge
    logic [NUM_BTN-1:0] pulse_d;
    logic [NUM_BTN-1:0] pulse_q;
    logic [NUM_BTN-1:0] level_q;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             s1_q;
            logic             s2_q;
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             req_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_q    <= 1'b0;
                    s2_q    <= 1'b0;
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    s1_q    <= bus.btn_raw[gi];
                    s2_q    <= s1_q;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Counter is cleared on every state change, so it only ever
            // measures how long s2 has disagreed with the accepted level.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                req_b   = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (s2_q) begin
                            state_d = PRESS_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s2_q) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            req_b   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!s2_q) begin
                            state_d = REL_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    REL_WAIT: begin
                        // Going back to HELD is release bounce: no request.
                        if (s2_q) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign req[gi]     = req_b;
            assign level_d[gi] = (state_d == HELD) || (state_d == REL_WAIT);
        end
    endgenerate

    // req & -req isolates the lowest set bit.
    always_comb begin
        pulse_d = req;
        if (ONE_HOT != 0) begin
            pulse_d = req & (~req + NUM_BTN'(1));
        end
    end

    // Outputs are registered on the same edge the FSM enters HELD, so the
    // pulse and the level rise together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
            level_q <= '0;
        end else begin
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign bus.btn_pulse = pulse_q;
    assign bus.btn_level = level_q;
endmodule

// File: tb/tb_btn_pulse_gen.sv
module tb_btn_pulse_gen;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btn_pulse_gen_if #(.NUM_BTN(3)) bus_oh ();
    btn_pulse_gen_if #(.NUM_BTN(3)) bus_ind ();

    btn_pulse_gen #(.NUM_BTN(3), .DB_CYCLES(DB), .CNT_W(3), .ONE_HOT(1)) dut_oh (
        .clk (clk),
        .rst (rst),
        .bus (bus_oh)
    );
    btn_pulse_gen #(.NUM_BTN(3), .DB_CYCLES(DB), .CNT_W(3), .ONE_HOT(0)) dut_ind (
        .clk (clk),
        .rst (rst),
        .bus (bus_ind)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a button's accepted level flips once the synchronized
    // input has disagreed with it for DB+1 consecutive samples; a flip to 1
    // is a press request.
    logic [2:0] m_s1, m_s2, m_lvl, m_pulse_oh, m_pulse_ind;
    int         m_run [3];

    // Per-scenario observation of the DUT pulses.
    int         oh_pulse_cycles, ind_pulse_cycles, ind_all_cycles;
    logic [2:0] oh_pulse_or, ind_pulse_or;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] pulse;
        logic [2:0] level;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse_oh = '0; m_pulse_ind = '0;
        for (int b = 0; b < 3; b++) m_run[b] = 0;
    endtask

    task automatic model_edge(input logic [2:0] raw);
        logic [2:0] r;
        r = '0;
        for (int b = 0; b < 3; b++) begin
            if (m_s2[b] != m_lvl[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == DB + 1) begin
                m_lvl[b] = ~m_lvl[b];
                m_run[b] = 0;
                if (m_lvl[b]) r[b] = 1'b1;
            end
        end
        m_pulse_ind = r;
        m_pulse_oh  = '0;
        for (int b = 2; b >= 0; b--) if (r[b]) m_pulse_oh = 3'b001 << b;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic scen_clear();
        oh_pulse_cycles = 0; ind_pulse_cycles = 0; ind_all_cycles = 0;
        oh_pulse_or = '0; ind_pulse_or = '0;
    endtask

    // Apply raw at the falling edge, run one rising edge, compare at the next falling edge.
    task automatic step(input logic [2:0] raw);
        bus_oh.btn_raw  = raw;
        bus_ind.btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
        $display("t=%0t raw=%b oh:p=%b l=%b ind:p=%b l=%b", $time, raw,
                 bus_oh.btn_pulse, bus_oh.btn_level, bus_ind.btn_pulse, bus_ind.btn_level);
        check("oh_pulse",  {29'd0, bus_oh.btn_pulse},  {29'd0, m_pulse_oh});
        check("oh_level",  {29'd0, bus_oh.btn_level},  {29'd0, m_lvl});
        check("ind_pulse", {29'd0, bus_ind.btn_pulse}, {29'd0, m_pulse_ind});
        check("ind_level", {29'd0, bus_ind.btn_level}, {29'd0, m_lvl});
        if (bus_oh.btn_pulse != 3'b000) oh_pulse_cycles++;
        if (bus_ind.btn_pulse != 3'b000) ind_pulse_cycles++;
        if (bus_ind.btn_pulse == 3'b111) ind_all_cycles++;
        oh_pulse_or  |= bus_oh.btn_pulse;
        ind_pulse_or |= bus_ind.btn_pulse;
    endtask

    // Rising edge with raw applied, then rst asserted between edges; outputs
    // must clear without waiting for a clock. Released at a falling edge.
    task automatic async_reset(input logic [2:0] raw);
        bus_oh.btn_raw  = raw;
        bus_ind.btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #2 rst = 1'b1;
        model_reset();
        #1;
        $display("t=%0t async reset asserted", $time);
        check("rst_oh_pulse",  {29'd0, bus_oh.btn_pulse},  32'd0);
        check("rst_oh_level",  {29'd0, bus_oh.btn_level},  32'd0);
        check("rst_ind_pulse", {29'd0, bus_ind.btn_pulse}, 32'd0);
        check("rst_ind_level", {29'd0, bus_ind.btn_level}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // After a reset release with button 0 held, find the edge of the fresh pulse.
    task automatic measure_press_after_reset(input string name);
        int pe;
        pe = 0;
        scen_clear();
        for (int j = 1; j <= 12; j++) begin
            step(3'b001);
            if (pe == 0 && bus_oh.btn_pulse[0]) pe = j;
        end
        check({name, "_pulse_edge"}, pe, DB + 3);
        check({name, "_pulse_count"}, oh_pulse_cycles, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] raw;
        int fall;

        // Clean press, first edge sampling 1 is edge 1: pulse exactly at edge 7.
        vecs[0] = '{3'b001, 3'b000, 3'b000};
        vecs[1] = '{3'b001, 3'b000, 3'b000};
        vecs[2] = '{3'b001, 3'b000, 3'b000};
        vecs[3] = '{3'b001, 3'b000, 3'b000};
        vecs[4] = '{3'b001, 3'b000, 3'b000};
        vecs[5] = '{3'b001, 3'b000, 3'b000};
        vecs[6] = '{3'b001, 3'b001, 3'b001};
        vecs[7] = '{3'b001, 3'b000, 3'b001};
        vecs[8] = '{3'b001, 3'b000, 3'b001};
        vecs[9] = '{3'b001, 3'b000, 3'b001};

        bus_oh.btn_raw  = '0;
        bus_ind.btn_raw = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_oh_pulse",  {29'd0, bus_oh.btn_pulse},  32'd0);
        check("reset_oh_level",  {29'd0, bus_oh.btn_level},  32'd0);
        check("reset_ind_level", {29'd0, bus_ind.btn_level}, 32'd0);
        rst = 1'b0;

        // Table: clean press.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].raw);
            check($sformatf("tbl%0d_oh_pulse", i),  {29'd0, bus_oh.btn_pulse},  {29'd0, vecs[i].pulse});
            check($sformatf("tbl%0d_oh_level", i),  {29'd0, bus_oh.btn_level},  {29'd0, vecs[i].level});
            check($sformatf("tbl%0d_ind_pulse", i), {29'd0, bus_ind.btn_pulse}, {29'd0, vecs[i].pulse});
        end

        // Release bounce: short release, short re-press, final release.
        scen_clear();
        step(3'b000); step(3'b000); step(3'b001); step(3'b001);
        fall = 0;
        for (int j = 1; j <= 12; j++) begin
            step(3'b000);
            if (fall == 0 && !bus_oh.btn_level[0]) fall = j;
        end
        check("relbounce_pulses", oh_pulse_cycles, 0);
        check("relbounce_fall_edge", fall, DB + 3);

        // Press bounce on button 1.
        scen_clear();
        step(3'b010); step(3'b000); step(3'b010); step(3'b000);
        for (int j = 0; j < 10; j++) step(3'b000);
        check("bounce_pulses", {29'd0, oh_pulse_or | ind_pulse_or}, 32'd0);
        check("bounce_level", {29'd0, bus_oh.btn_level}, 32'd0);

        // Simultaneous press.
        scen_clear();
        for (int j = 0; j < 12; j++) step(3'b111);
        check("simul_oh_or", {29'd0, oh_pulse_or}, 32'd1);
        check("simul_oh_cycles", oh_pulse_cycles, 1);
        check("simul_ind_all_cycles", ind_all_cycles, 1);
        check("simul_ind_cycles", ind_pulse_cycles, 1);
        check("simul_level", {29'd0, bus_oh.btn_level}, 32'd7);
        for (int j = 0; j < 12; j++) step(3'b000);

        // Long hold on button 2: no auto-repeat.
        scen_clear();
        for (int j = 0; j < 100; j++) step(3'b100);
        check("hold_oh_cycles", oh_pulse_cycles, 1);
        check("hold_oh_or", {29'd0, oh_pulse_or}, 32'd4);
        for (int j = 0; j < 12; j++) step(3'b000);

        // Reset while held, release with button still pressed: fresh press.
        for (int j = 0; j < 10; j++) step(3'b001);
        async_reset(3'b001);
        measure_press_after_reset("held_rst");

        // Reset at edge 5 of a press: that press is abandoned.
        for (int j = 0; j < 12; j++) step(3'b000);
        for (int j = 0; j < 4; j++) step(3'b001);
        async_reset(3'b001);
        measure_press_after_reset("mid_rst");
        for (int j = 0; j < 12; j++) step(3'b000);

        // Randomized stimulus against the model, alternating bouncy and calm phases.
        raw = '0;
        for (int n = 0; n < 1000; n++) begin
            int p;
            p = ((n / 100) % 2 == 1) ? 2 : 14;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, p) == 0) raw[b] = ~raw[b];
            if ($urandom_range(0, 299) == 0) async_reset(raw);
            else step(raw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
